prio_encoder_pipe: RTL and testbench
====================================

Name: prio_encoder_pipe

Overview:
- Parametrised N-to-log2(N) priority encoder with a registered output stage and valid/ready handshake on both sides.
- Generalises the team's 4:2 combinational encoder to any width.
- Adds a multi-hot flag and backpressure.
- Used wherever request vectors are converted to an index, e.g. interrupt or arbiter front ends.

Parameters:
- N, 4, number of request inputs; legal range 2..256.
- W, $clog2(N), code width; derived, do not override.
- HIGH_FIRST, 1, fixed-priority direction: 1 means the highest set index wins, 0 means the lowest set index wins.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request vector is presented.
- in_ready  out  1  block can accept a vector this cycle.
- in_req  in  N  request vector.
- out_valid  out  1  encoded result is held.
- out_ready  in  1  downstream accepts the result.
- out_code  out  W  index of the winning bit.
- out_hit  out  1  at least one request bit was set.
- out_multi  out  1  more than one request bit was set.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: out_valid=0, out_code=0, out_hit=0, out_multi=0, internal rr_ptr=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A transfer in occurs when in_valid && in_ready.
  - A transfer out occurs when out_valid && out_ready.
- Latency: one cycle. A vector accepted at edge k is visible on the outputs after edge k, with out_valid=1.
- Capture: on a transfer in, register out_code, out_hit, out_multi and set out_valid=1.
- Hold: if there is no transfer in and a transfer out occurs, clear out_valid=0. out_code, out_hit and out_multi keep their last values.
- Simultaneous out-transfer and in-transfer in the same cycle: the new result replaces the old one and out_valid stays 1. Full throughput is 1 per cycle.
- Stall: while out_valid && !out_ready, all outputs stay stable. in_ready=0 and in_req is ignored.
- All-zero request: out_hit=0, out_code=0, out_multi=0. It is still a valid transfer with out_valid=1.
- out_multi = popcount(in_req) > 1.
- Reset mid-operation: outputs return to reset values immediately. The pending result is lost and is not replayed.
- X on in_req while in_valid=0 has no effect on the outputs.

Optional Feature:
- Macro: PRIO_ENC_ROUND_ROBIN_EN.
- Defined:
  - Priority rotates. The search starts at index rr_ptr and scans upward, wrapping at N-1 to 0. HIGH_FIRST is ignored.
  - On each transfer in with out_hit=1, rr_ptr <= (winning code + 1) mod N.
  - rr_ptr is unchanged on an all-zero transfer or when there is no transfer.
- Undefined: rr_ptr does not exist. Encoding is fixed priority per HIGH_FIRST. Port list is identical in both builds.

Decomposition:
- Package prio_enc_pkg holds:
  - constant function clog2;
  - constant PRIO_ENC_MAX_N = 256;
  - packed result typedef {code, hit, multi}.
- Sub-module prio_enc_core: purely combinational fixed-priority encoder (N, HIGH_FIRST) that produces code/hit/multi.
- Round-robin mode reuses prio_enc_core: rotate in_req right by rr_ptr, encode lowest-first, then add rr_ptr mod N to the code.
- Top level owns the registers, the handshake and rr_ptr.

Test Plan:
- Reset, N=4: hold rst_n=0 with in_valid=1 → all outputs 0 and out_valid=0. Release → the first vector is accepted on the next edge.
- N=4, HIGH_FIRST=1, out_ready=1: send 0001, 0010, 0100, 1000, 1111, 0011, 0110, 1001 on back-to-back cycles.
  - Expected codes 0,1,2,3,3,1,2,3 one cycle later.
  - Expected out_multi 0,0,0,0,1,1,1,1.
  - out_hit=1 for all.
- All-zero: in_req=0000 → out_valid=1, out_hit=0, out_code=00, out_multi=0.
- Backpressure: hold out_ready=0 after capturing 0100 (code 2), then drive in_req=1000 for 3 cycles → in_ready=0, out_code stays 2. Raise out_ready → 2 is consumed, then 3 appears. No vector is lost or duplicated.
- HIGH_FIRST=0, N=8, in_req=8'b1010_0100 → out_code=2, out_multi=1.
- With PRIO_ENC_ROUND_ROBIN_EN, N=4: send in_req=1111 four times → codes 0,1,2,3, then 0 again. Then send 0001 with rr_ptr=1 → code 0 (wrap), and rr_ptr becomes 1.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared definitions for the pipelined priority encoder family.
// Holds the code-width helper, the widest supported request vector and
// the packed result record carried from the encoder core to the output stage.
package prio_enc_pkg;

  localparam int PRIO_ENC_MAX_N = 256;

  // Smallest w with (1 << w) >= value, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int PRIO_ENC_CODE_W = clog2(PRIO_ENC_MAX_N);

  // The code field is sized for the widest encoder; narrower instances
  // keep the unused upper bits at zero and truncate on the way out.
  typedef struct packed {
    logic [PRIO_ENC_CODE_W-1:0] code;
    logic                       hit;
    logic                       multi;
  } prio_enc_result_t;

endpackage

// File: rtl/prio_enc_core.sv
// Purely combinational fixed-priority encoder.
// HIGH_FIRST=1 reports the highest set index, HIGH_FIRST=0 the lowest.
// Also flags whether any bit was set and whether more than one was set.
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter int N          = 4,
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [N-1:0]      req,
  output prio_enc_result_t  res
);

  // Scan the vector once for hit/multi, then let the last matching index in scan order win.
  always_comb begin
    res = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (res.hit) begin
          res.multi = 1'b1;
        end
        res.hit = 1'b1;
      end
    end
    if (HIGH_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          res.code = PRIO_ENC_CODE_W'(i);
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          res.code = PRIO_ENC_CODE_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/prio_encoder_pipe.sv
// N-to-log2(N) priority encoder with a registered output stage and
// valid/ready handshakes on both sides; accepts one vector per cycle.
// Optional feature: define PRIO_ENC_ROUND_ROBIN_EN to rotate priority,
// starting the search at rr_ptr and advancing it past each winner.
// Without the macro the encoder is fixed priority per HIGH_FIRST.
module prio_encoder_pipe
  import prio_enc_pkg::*;
#(
  parameter int N          = 4,
  parameter int W          = clog2(N),
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_hit,
  output logic         out_multi
);

  prio_enc_result_t core_res;
  prio_enc_result_t next_res;
  prio_enc_result_t res_q;
  logic             in_xfer;

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [W-1:0] rr_ptr;
  logic [N-1:0] rotated_req;
  logic [W:0]   win_sum;
  logic [W:0]   win_code;
  logic [W:0]   next_ptr;

  // Rotating right by rr_ptr puts the search start at bit 0, so a lowest-first
  // encode of the rotated vector finds the first set bit at or after rr_ptr.
  assign rotated_req = N'({in_req, in_req} >> rr_ptr);

  prio_enc_core #(
    .N          (N),
    .HIGH_FIRST (1'b0)
  ) u_core (
    .req (rotated_req),
    .res (core_res)
  );

  // Map the rotated index back to an absolute index and work out where the next search starts.
  always_comb begin
    win_sum  = (W+1)'(rr_ptr) + (W+1)'(W'(core_res.code));
    win_code = (win_sum >= (W+1)'(N)) ? (win_sum - (W+1)'(N)) : win_sum;
    next_ptr = win_code + (W+1)'(1);
    if (next_ptr == (W+1)'(N)) begin
      next_ptr = '0;
    end
    next_res      = core_res;
    next_res.code = core_res.hit ? PRIO_ENC_CODE_W'(win_code) : '0;
  end

  // Move the start point past the winner of every accepted non-empty vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (in_xfer && core_res.hit) begin
      rr_ptr <= W'(next_ptr);
    end
  end
`else
  prio_enc_core #(
    .N          (N),
    .HIGH_FIRST (HIGH_FIRST)
  ) u_core (
    .req (in_req),
    .res (core_res)
  );

  assign next_res = core_res;
`endif

  // Output stage: capture on accept, drop valid once consumed, otherwise hold everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      res_q     <= next_res;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_code  = W'(res_q.code);
  assign out_hit   = res_q.hit;
  assign out_multi = res_q.multi;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Self-checking bench for prio_encoder_pipe.
// Drives a 4-input high-first instance and an 8-input low-first instance
// with shared handshake inputs and compares both against a behavioural model.
// Follows PRIO_ENC_ROUND_ROBIN_EN in the same way the design does.
module tb_prio_encoder_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] req4;
  logic [7:0] req8;

  logic       rdy4, valid4, hit4, multi4;
  logic [1:0] code4;
  logic       rdy8, valid8, hit8, multi8;
  logic [2:0] code8;

  typedef struct {
    int code;
    bit hit;
    bit multi;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   pending [2];
  res_t last    [2];
  int   ptr     [2];

  logic [3:0] seq_vec    [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b1111, 4'b0011, 4'b0110, 4'b1001};
  int         seq_code   [8] = '{0, 1, 2, 3, 3, 1, 2, 3};
  int         seq_multi  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  prio_encoder_pipe #(.N(4), .HIGH_FIRST(1'b1)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (rdy4),
    .in_req    (req4),
    .out_valid (valid4),
    .out_ready (out_ready),
    .out_code  (code4),
    .out_hit   (hit4),
    .out_multi (multi4)
  );

  prio_encoder_pipe #(.N(8), .HIGH_FIRST(1'b0)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (rdy8),
    .in_req    (req8),
    .out_valid (valid8),
    .out_ready (out_ready),
    .out_code  (code8),
    .out_hit   (hit8),
    .out_multi (multi8)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Reference encode straight from the rules: count the ones, then walk the
  // indices in priority order and take the first set one.
  function automatic res_t refEncode(input logic [7:0] req, input int n, input bit hf, input int start);
    res_t r;
    int   cnt;
    int   idx;
    r.code  = 0;
    r.hit   = 1'b0;
    r.multi = 1'b0;
    cnt     = 0;
    for (int i = 0; i < n; i++) begin
      if (req[i]) cnt++;
    end
    r.hit   = (cnt > 0);
    r.multi = (cnt > 1);
    for (int k = 0; k < n; k++) begin
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      idx = (start + k) % n;
`else
      idx = hf ? (n - 1 - k) : k;
`endif
      if (req[idx]) begin
        r.code = idx;
        break;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      pending[d]    = 0;
      last[d].code  = 0;
      last[d].hit   = 1'b0;
      last[d].multi = 1'b0;
      ptr[d]        = 0;
    end
  endtask

  // One clock edge of the model: a result leaves when it is held and taken,
  // a new vector enters when offered and there is room (or room is being made).
  task automatic modelEdge(input int d, input int n, input bit hf, input bit v, input logic [7:0] req, input bit rdy);
    bit accept;
    accept = v && (pending[d] == 0 || rdy);
    if (pending[d] > 0 && rdy) pending[d]--;
    if (accept) begin
      last[d] = refEncode(req, n, hf, ptr[d]);
      pending[d]++;
      if (last[d].hit) ptr[d] = (last[d].code + 1) % n;
    end
  endtask

  task automatic checkAll(input string phase);
    checkOutput({phase, "/valid4"}, 32'(valid4), 32'(pending[0] > 0));
    checkOutput({phase, "/code4"},  32'(code4),  32'(last[0].code));
    checkOutput({phase, "/hit4"},   32'(hit4),   32'(last[0].hit));
    checkOutput({phase, "/multi4"}, 32'(multi4), 32'(last[0].multi));
    checkOutput({phase, "/valid8"}, 32'(valid8), 32'(pending[1] > 0));
    checkOutput({phase, "/code8"},  32'(code8),  32'(last[1].code));
    checkOutput({phase, "/hit8"},   32'(hit8),   32'(last[1].hit));
    checkOutput({phase, "/multi8"}, 32'(multi8), 32'(last[1].multi));
  endtask

  // Drive one cycle of inputs at the falling edge, check in_ready, then check outputs just after the rising edge.
  task automatic applyStimulus(input string phase, input bit v, input logic [3:0] r4, input logic [7:0] r8, input bit rdy);
    @(negedge clk);
    in_valid  = v;
    req4      = r4;
    req8      = r8;
    out_ready = rdy;
    #1;
    checkOutput({phase, "/ready4"}, 32'(rdy4), 32'(pending[0] == 0 || rdy));
    checkOutput({phase, "/ready8"}, 32'(rdy8), 32'(pending[1] == 0 || rdy));
    @(posedge clk);
    modelEdge(0, 4, 1'b1, v, {4'b0000, r4}, rdy);
    modelEdge(1, 8, 1'b0, v, r8, rdy);
    #1;
    checkAll(phase);
  endtask

  // Assert reset between edges while a result is held; outputs must clear at once.
  task automatic midReset();
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll("midreset");
    @(posedge clk);
    #1;
    checkAll("midreset_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    req4      = 4'hF;
    req8      = 8'hFF;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkAll("reset");
    checkOutput("reset/ready4", 32'(rdy4), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus("seq", 1'b1, seq_vec[i], 8'($urandom), 1'b1);
      checkOutput("seq/table_multi", 32'(multi4), 32'(seq_multi[i]));
`ifndef PRIO_ENC_ROUND_ROBIN_EN
      checkOutput("seq/table_code", 32'(code4), 32'(seq_code[i]));
`endif
    end

    applyStimulus("zero", 1'b1, 4'b0000, 8'h00, 1'b1);
    checkOutput("zero/valid_const", 32'(valid4), 32'd1);
    checkOutput("zero/hit_const", 32'(hit4), 32'd0);
    checkOutput("zero/code_const", 32'(code4), 32'd0);

    applyStimulus("n8", 1'b1, 4'($urandom), 8'b1010_0100, 1'b1);
`ifndef PRIO_ENC_ROUND_ROBIN_EN
    checkOutput("n8/code_const", 32'(code8), 32'd2);
`endif
    checkOutput("n8/multi_const", 32'(multi8), 32'd1);

    applyStimulus("bp_cap", 1'b1, 4'b0100, 8'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("bp_stall", 1'b1, 4'b1000, 8'($urandom), 1'b0);
      checkOutput("bp_stall/ready_const", 32'(rdy4), 32'd0);
    end
    applyStimulus("bp_swap", 1'b1, 4'b1000, 8'($urandom), 1'b1);
    checkOutput("bp_swap/code_const", 32'(code4), 32'd3);
    applyStimulus("bp_drain", 1'b0, 4'($urandom), 8'($urandom), 1'b1);

    applyStimulus("pre_reset", 1'b1, 4'b0010, 8'($urandom), 1'b0);
    midReset();

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    for (int i = 0; i < 5; i++) begin
      applyStimulus("rr_all", 1'b1, 4'b1111, 8'hFF, 1'b1);
      checkOutput("rr_all/code_const", 32'(code4), 32'(i % 4));
    end
    applyStimulus("rr_wrap", 1'b1, 4'b0001, 8'h01, 1'b1);
    checkOutput("rr_wrap/code_const", 32'(code4), 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
